// File: rtl/vending_machine_controller.sv
// Vending machine control core: balance register, inactivity timer and
// largest-coin-first change return sequencer.
module vending_machine_controller #(
  parameter int unsigned kNumCoins  = 3,
  parameter int unsigned kNumItems  = 4,
  parameter int unsigned kTotalBits = 31,
  parameter int unsigned kWaitTime  = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [kNumCoins-1:0]  i_input_coin,
  input  logic [kNumItems-1:0]  i_select_item,
  input  logic                  i_trigger_return,
  output logic [kNumItems-1:0]  o_available_item,
  output logic [kNumItems-1:0]  o_output_item,
  output logic [kNumCoins-1:0]  o_return_coin,
  output logic [kTotalBits-1:0] o_current_total
);

  localparam int unsigned kWaitBits = $clog2(kWaitTime + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_RETURN} state_t;

  function automatic logic [kTotalBits-1:0] coin_value(input int unsigned idx);
    case (idx)
      0:       return kTotalBits'(100);
      1:       return kTotalBits'(500);
      default: return kTotalBits'(1000);
    endcase
  endfunction

  function automatic logic [kTotalBits-1:0] item_price(input int unsigned idx);
    case (idx)
      0:       return kTotalBits'(400);
      1:       return kTotalBits'(500);
      2:       return kTotalBits'(1000);
      default: return kTotalBits'(2000);
    endcase
  endfunction

  state_t                 state, state_nxt;
  logic [kTotalBits-1:0]  total, total_nxt;
  logic [kWaitBits-1:0]   wait_cnt, wait_cnt_nxt;
  logic [kNumItems-1:0]   out_item_nxt;

  logic [kTotalBits-1:0]  coin_sum, coin_add, r, ret_val;
  logic [kNumItems-1:0]   dispensed;
  logic [kNumCoins-1:0]   ret_onehot;
  logic                   reload;

  always_comb begin
    coin_sum = '0;
    for (int unsigned i = 0; i < kNumCoins; i++)
      if (i_input_coin[i]) coin_sum = coin_sum + coin_value(i);
    // ~total is the remaining headroom below the all-ones balance
    coin_add = (coin_sum > ~total) ? '0 : coin_sum;

    r         = total;
    dispensed = '0;
    for (int unsigned i = 0; i < kNumItems; i++)
      if (i_select_item[i] && (r >= item_price(i))) begin
        dispensed[i] = 1'b1;
        r            = r - item_price(i);
      end

    // Coin values ascend with index, so the last match is the largest
    ret_onehot = '0;
    ret_val    = '0;
    for (int unsigned i = 0; i < kNumCoins; i++)
      if (total >= coin_value(i)) begin
        ret_onehot    = '0;
        ret_onehot[i] = 1'b1;
        ret_val       = coin_value(i);
      end

    reload = (coin_sum != '0) || (dispensed != '0);
  end

  always_comb begin
    state_nxt    = state;
    total_nxt    = total;
    wait_cnt_nxt = wait_cnt;
    out_item_nxt = '0;
    case (state)
      ST_IDLE: begin
        if (coin_sum != '0) begin
          state_nxt    = ST_ACTIVE;
          total_nxt    = coin_sum;
          wait_cnt_nxt = kWaitBits'(kWaitTime);
        end
      end
      ST_ACTIVE: begin
        out_item_nxt = dispensed;
        total_nxt    = r + coin_add;
        wait_cnt_nxt = reload ? kWaitBits'(kWaitTime) : wait_cnt - kWaitBits'(1);
        if (i_trigger_return || (!reload && (wait_cnt == kWaitBits'(1))))
          state_nxt = ST_RETURN;
        else if (total_nxt == '0)
          state_nxt = ST_IDLE;
      end
      ST_RETURN: begin
        total_nxt = total - ret_val + coin_add;
        if (total_nxt == '0) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      total         <= '0;
      wait_cnt      <= '0;
      o_output_item <= '0;
    end else begin
      state         <= state_nxt;
      total         <= total_nxt;
      wait_cnt      <= wait_cnt_nxt;
      o_output_item <= out_item_nxt;
    end
  end

  always_comb begin
    o_available_item = '0;
    for (int unsigned i = 0; i < kNumItems; i++)
      o_available_item[i] = (state == ST_ACTIVE) && (total >= item_price(i));
  end

  assign o_return_coin   = (state == ST_RETURN) ? ret_onehot : '0;
  assign o_current_total = total;

endmodule

// File: tb/tb_vending_machine_controller.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the vending controller.
module tb_vending_machine_controller;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  i_input_coin = '0;
  logic [3:0]  i_select_item = '0;
  logic        i_trigger_return = 1'b0;
  logic [3:0]  o_available_item;
  logic [3:0]  o_output_item;
  logic [2:0]  o_return_coin;
  logic [30:0] o_current_total;

  vending_machine_controller #(
    .kNumCoins(3), .kNumItems(4), .kTotalBits(31), .kWaitTime(10)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .i_input_coin     (i_input_coin),
    .i_select_item    (i_select_item),
    .i_trigger_return (i_trigger_return),
    .o_available_item (o_available_item),
    .o_output_item    (o_output_item),
    .o_return_coin    (o_return_coin),
    .o_current_total  (o_current_total)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: plain integers, session flags and a countdown.
  int unsigned coin_val[3]  = '{100, 500, 1000};
  int unsigned price_val[4] = '{400, 500, 1000, 2000};
  longint m_total;
  bit     m_in_session;
  bit     m_paying;
  int     m_timer;
  bit [3:0] m_out;

  task automatic model_reset();
    m_total = 0; m_in_session = 0; m_paying = 0; m_timer = 0; m_out = '0;
  endtask

  function automatic longint largest_coin(input longint amt, output int idx);
    idx = -1;
    for (int i = 2; i >= 0; i--)
      if (idx < 0 && amt >= coin_val[i]) idx = i;
    return (idx < 0) ? 0 : coin_val[idx];
  endfunction

  task automatic model_step(input logic [2:0] c, input logic [3:0] s, input logic t);
    longint csum, bal, pay;
    bit busy, expired;
    int idx;
    csum = 0;
    for (int i = 0; i < 3; i++) if (c[i]) csum += coin_val[i];
    busy = (csum != 0);
    if (m_total + csum > 64'h7FFF_FFFF) csum = 0;
    m_out = '0;
    if (m_paying) begin
      pay = largest_coin(m_total, idx);
      m_total = m_total - pay + csum;
      if (m_total == 0) m_paying = 0;
    end else if (m_in_session) begin
      bal = m_total;
      for (int i = 0; i < 4; i++)
        if (s[i] && bal >= price_val[i]) begin
          m_out[i] = 1'b1;
          bal -= price_val[i];
        end
      busy    = busy || (m_out != 0);
      expired = !busy && (m_timer == 1);
      m_timer = busy ? 10 : m_timer - 1;
      m_total = bal + csum;
      if (t || expired) begin
        m_in_session = 0; m_paying = 1;
      end else if (m_total == 0) begin
        m_in_session = 0;
      end
    end else if (csum != 0) begin
      m_in_session = 1; m_total = csum; m_timer = 10;
    end
  endtask

  task automatic check_outputs();
    logic [3:0] exp_avail;
    logic [2:0] exp_ret;
    longint dummy;
    int idx;
    exp_avail = '0;
    for (int i = 0; i < 4; i++)
      if (m_in_session && m_total >= price_val[i]) exp_avail[i] = 1'b1;
    exp_ret = '0;
    if (m_paying) begin
      dummy = largest_coin(m_total, idx);
      if (idx >= 0) exp_ret = 3'b001 << idx;
    end
    check_val("total", 64'(o_current_total), m_total);
    check_val("avail", 64'(o_available_item), 64'(exp_avail));
    check_val("out_item", 64'(o_output_item), 64'(m_out));
    check_val("ret_coin", 64'(o_return_coin), 64'(exp_ret));
  endtask

  // Entered and left at posedge+1.
  task automatic cycle(input logic [2:0] c, input logic [3:0] s, input logic t);
    i_input_coin = c; i_select_item = s; i_trigger_return = t;
    @(posedge clk);
    model_step(c, s, t);
    #1;
    check_outputs();
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) cycle('0, '0, 1'b0);
  endtask

  task automatic async_reset();
    #3;
    i_input_coin = '0; i_select_item = '0; i_trigger_return = 1'b0;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_val("rst_total", 64'(o_current_total), 0);
    check_val("rst_avail", 64'(o_available_item), 0);
    check_val("rst_out", 64'(o_output_item), 0);
    check_val("rst_ret", 64'(o_return_coin), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", n_total, n_bad + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    #2;
    check_val("init_total", 64'(o_current_total), 0);
    check_val("init_ret", 64'(o_return_coin), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // IDLE ignores selects and trigger
    cycle('0, 4'hF, 1'b1);
    check_val("idle_ign", 64'(o_current_total), 0);

    // 1000 in, buy item1
    cycle(3'b100, '0, 1'b0);
    cycle('0, 4'b0010, 1'b0);
    check_val("buy1_out", 64'(o_output_item), 64'(4'b0010));
    check_val("buy1_total", 64'(o_current_total), 500);
    cycle('0, '0, 1'b0);
    check_val("buy1_pulse", 64'(o_output_item), 0);
    check_val("buy1_avail", 64'(o_available_item), 64'(4'b0011));
    cycle('0, '0, 1'b1);
    idle_cycles(3);

    // 800, select items 0 and 1 together
    cycle(3'b011, '0, 1'b0);
    cycle(3'b001, '0, 1'b0);
    cycle(3'b001, '0, 1'b0);
    check_val("t800", 64'(o_current_total), 800);
    cycle('0, 4'b0011, 1'b0);
    check_val("prio_out", 64'(o_output_item), 64'(4'b0001));
    check_val("prio_total", 64'(o_current_total), 400);
    cycle('0, '0, 1'b0);
    check_val("prio_avail", 64'(o_available_item), 64'(4'b0001));
    cycle('0, '0, 1'b1);
    idle_cycles(6);

    // 1600 payout sequence
    cycle(3'b111, '0, 1'b0);
    cycle('0, '0, 1'b1);
    check_val("pay_1000", 64'(o_return_coin), 64'(3'b100));
    cycle('0, '0, 1'b0);
    check_val("pay_500", 64'(o_return_coin), 64'(3'b010));
    cycle('0, '0, 1'b0);
    check_val("pay_100", 64'(o_return_coin), 64'(3'b001));
    cycle('0, '0, 1'b0);
    check_val("pay_done_total", 64'(o_current_total), 0);
    check_val("pay_done_ret", 64'(o_return_coin), 0);

    // Timeout after a single 500 coin
    cycle(3'b010, '0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      cycle('0, '0, 1'b0);
      check_val("timeout_ret", 64'(o_return_coin), (k == 10) ? 64'd2 : 64'd0);
    end
    cycle('0, '0, 1'b0);
    check_val("timeout_idle", 64'(o_current_total), 0);

    // Unaffordable select does not reload the timer
    for (int k = 0; k < 4; k++) cycle(3'b001, '0, 1'b0);
    for (int k = 0; k < 9; k++) cycle('0, 4'b1000, 1'b0);
    check_val("noreload_out", 64'(o_output_item), 0);
    cycle('0, 4'b1000, 1'b0);
    check_val("noreload_ret", 64'(o_return_coin), 64'(3'b001));
    idle_cycles(5);

    // Reset during payout of 1100 after the first coin
    cycle(3'b101, '0, 1'b0);
    cycle('0, '0, 1'b1);
    cycle('0, '0, 1'b0);
    check_val("mid_pay_ret", 64'(o_return_coin), 64'(3'b001));
    async_reset();

    // Randomized traffic with occasional quiet stretches and resets
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] c;
      logic [3:0] s;
      logic       t;
      if ((n % 150) > 130) begin
        c = '0; s = '0; t = 1'b0;
      end else begin
        c = ($urandom_range(0, 99) < 30) ? 3'($urandom_range(1, 7)) : 3'b000;
        s = ($urandom_range(0, 99) < 35) ? 4'($urandom_range(1, 15)) : 4'b0000;
        t = ($urandom_range(0, 99) < 3);
      end
      cycle(c, s, t);
      if ($urandom_range(0, 499) == 0) async_reset();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
